mux2_rr_feeder: RTL
===================

Name: mux2_rr_feeder

Overview:
- Upstream stage of the 8-bit `mux2to1`. It drives that mux's `d0`, `d1` and `sel` inputs.
- Accepts data from two independent producers over valid/ready handshakes and holds each word in a one-entry slot.
- Round-robin arbitrates between full slots and drives the registered `sel`, plus `out_valid`/`out_ready` toward the consumer of the mux output.
- The consumer samples `mux2to1.out` when `out_valid && out_ready`.

Parameters:
- WIDTH, 8, data width of slots and mux legs.
- CNT_W, 8, width of per-channel transfer counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in0_data  input  WIDTH  producer 0 data
- in0_valid  input  1  producer 0 valid
- in0_ready  output  1  slot 0 can accept
- in1_data  input  WIDTH  producer 1 data
- in1_valid  input  1  producer 1 valid
- in1_ready  output  1  slot 1 can accept
- d0  output  WIDTH  slot 0 contents, to mux d0
- d1  output  WIDTH  slot 1 contents, to mux d1
- sel  output  1  registered grant, to mux sel (0 selects d0)
- out_valid  output  1  mux output holds a granted word
- out_ready  input  1  consumer accepts the word
- cnt0  output  CNT_W  completed transfers from slot 0
- cnt1  output  CNT_W  completed transfers from slot 1

Behaviour:
- Reset (async assert, sync release): full0=full1=0, d0=d1=0, sel=0, out_valid=0, last=1, cnt0=cnt1=0, state=IDLE.
- Readiness: inN_ready = !fullN, registered-flag based with no combinational path from out_ready.
- Capture: inN_valid && inN_ready at an edge loads dN <= inN_data and sets fullN.
  - dN is held unchanged while fullN=1.
  - A slot drained at edge k shows ready after edge k, so refill happens at edge k+1 at the earliest.
- FSM states:
  - IDLE: out_valid=0.
  - PRESENT: out_valid=1.
- Arbitration occurs at an edge where state=IDLE, or where state=PRESENT and a transfer occurs. Candidates are the full slots, excluding the slot being drained this edge.
  - No candidate: go to or stay in IDLE.
  - One candidate: grant it.
  - Two candidates: grant !last.
  - On grant: sel <= granted index, last <= granted index, state <= PRESENT.
- Transfer (out_valid && out_ready):
  - full[sel] cleared and cnt[sel] incremented, wrapping at 2^CNT_W.
  - With the other slot full, the next grant happens the same edge: out_valid stays 1 and sel flips, giving back-to-back transfers with no bubble.
- Stability: while out_valid && !out_ready, sel, out_valid and d[sel] are held unchanged.
- Latency: a word captured at edge k gives out_valid=1 after edge k+1 if the block was IDLE. Minimum input-to-output latency is 2 cycles from in_valid assertion.
- Simultaneous capture on both channels at the same edge is legal. Tie-break uses last (after reset, channel 0 wins first).
- A capture on slot N in the same cycle as a transfer from slot N cannot occur, since ready=0 while full.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Any in-flight word is dropped and out_valid drops without waiting for a clock.
- The arbiter never grants an empty slot. out_valid=1 implies full[sel]=1.

Decomposition:
- Package mux2_feed_pkg:
  - state enum {IDLE, PRESENT}
  - default WIDTH and CNT_W localparams
  - channel index constants CH0=0, CH1=1
- Sub-module mux2_slot (one instance per channel): holds data register, full flag, ready output, capture and clear logic, and transfer counter.
- Top level holds the FSM, the round-robin `last` register and the `sel` register.
- mux2to1 is instantiated beside this block by the integrator, not inside it.

Test Plan:
- Reset then idle: rst pulse with no valids -> d0=d1=0, sel=0, out_valid=0, in0_ready=in1_ready=1, cnt0=cnt1=0.
- Single channel: in0_data=8'h71 with valid for one cycle, out_ready=1 -> out_valid high for exactly one cycle with sel=0, mux out=8'h71; cnt0=1, in0_ready returns to 1.
- Tie and round robin: in0=8'h01, in1=8'h04 captured the same edge, out_ready=1 -> sel=0 then sel=1 on consecutive cycles with no bubble. Mux out is 8'h01 then 8'h04; cnt0=cnt1=1.
- Backpressure: slot1=8'h06 presented with out_ready=0 for 5 cycles -> sel=1, d1=8'h06 and out_valid held stable. in1_ready=0 and a new in1_valid is not captured; transfer occurs on the cycle out_ready rises.
- Fairness under load: both producers valid continuously with out_ready=1 for 20 transfers -> sel strictly alternates and cnt0=cnt1=10.
- Wrap and reset: with CNT_W=2, 5 transfers on channel 0 -> cnt0=1. Then assert rst while out_valid=1 -> out_valid and full flags clear immediately before the next clk edge.

Source files
------------

// File: rtl/mux2_feed_pkg.sv
// Shared types and constants for the two-producer round-robin mux feeder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mux2_feed_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

    // Channel indices as seen on the mux select line
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/mux2_slot.sv
// One-entry holding slot for a single producer, with a transfer counter.
// Latency: a word is held starting the edge after the valid/ready handshake.
// Backpressure: ready is simply !full; there is no combinational path from downstream.
// Ports: in_data/in_valid/ready = producer side; drain = word leaves this edge;
//        data/full = slot contents to the arbiter and mux; cnt = completed drains.
module mux2_slot
    import mux2_feed_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             ready,
    input  logic             drain,
    output logic [WIDTH-1:0] data,
    output logic             full,
    output logic [CNT_W-1:0] cnt
);

    assign ready = !full;

    // drain is only ever raised while full, and capture needs !full, so the
    // two branches never compete. data is left as-is on drain so the mux leg
    // keeps its last value rather than glitching to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            full <= 1'b0;
            cnt  <= '0;
        end else if (drain) begin
            full <= 1'b0;
            cnt  <= cnt + CNT_W'(1);
        end else if (in_valid && !full) begin
            data <= in_data;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/mux2_rr_feeder.sv
// Round-robin feeder for a 2:1 mux: two one-entry slots, registered sel and out_valid.
// Latency: capture at edge k -> out_valid after edge k+1 when idle; back-to-back with no bubble.
// Backpressure: while out_valid && !out_ready, sel and the selected slot are frozen.
// Ports: in0_*/in1_* = producer handshakes; d0/d1/sel = mux inputs;
//        out_valid/out_ready = consumer handshake on the mux output; cnt0/cnt1 = transfers.
module mux2_rr_feeder
    import mux2_feed_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    state_t state, state_nxt;
    logic   sel_nxt;
    logic   last, last_nxt;
    logic   full0, full1;
    logic   xfer, drain0, drain1;
    logic   cand0, cand1;
    logic   grant;

    assign out_valid = (state == PRESENT);
    assign xfer      = out_valid && out_ready;
    assign drain0    = xfer && (sel == CH0);
    assign drain1    = xfer && (sel == CH1);

    // A slot emptying this edge must not be re-granted from its stale flag.
    assign cand0 = full0 && !drain0;
    assign cand1 = full1 && !drain1;

    mux2_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in0_data),
        .in_valid (in0_valid),
        .ready    (in0_ready),
        .drain    (drain0),
        .data     (d0),
        .full     (full0),
        .cnt      (cnt0)
    );

    mux2_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in1_data),
        .in_valid (in1_valid),
        .ready    (in1_ready),
        .drain    (drain1),
        .data     (d1),
        .full     (full1),
        .cnt      (cnt1)
    );

    // Arbitrate only when nothing is being presented or the presented word
    // leaves this edge; otherwise hold everything for the consumer.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        last_nxt  = last;
        grant     = 1'b0;
        if ((state == IDLE) || xfer) begin
            if (!cand0 && !cand1) begin
                state_nxt = IDLE;
            end else begin
                if (cand0 && cand1) begin
                    grant = !last;
                end else begin
                    grant = cand1 ? CH1 : CH0;
                end
                state_nxt = PRESENT;
                sel_nxt   = grant;
                last_nxt  = grant;
            end
        end
    end

    // last resets to channel 1 so channel 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= CH0;
            last  <= CH1;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            last  <= last_nxt;
        end
    end

endmodule
